// File: rtl/hemps_defaults.sv
// Shared defaults and types for the router input-port VC buffer.
package hemps_defaults;

  localparam int unsigned FLIT_WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF      = 16;
  localparam int unsigned NVC_DEF        = 2;

  typedef logic [FLIT_WIDTH_DEF-1:0] flit_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HEADER,
    S_SIZE,
    S_PAYLOAD,
    S_END
  } out_state_e;

  // Width of a VC index; a single VC still gets a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned nvc);
    return (nvc > 1) ? $clog2(nvc) : 1;
  endfunction

endpackage

// File: rtl/router_vc_buffer_if.sv
// Upstream link, switch-control handshake and crossbar port of one router input.
interface router_vc_buffer_if
  import hemps_defaults::*;
#(
  parameter int unsigned FLIT_WIDTH = FLIT_WIDTH_DEF,
  parameter int unsigned NVC        = NVC_DEF
);

  localparam int unsigned SEL_W = sel_width(NVC);

  logic [NVC-1:0]        rx;
  logic [FLIT_WIDTH-1:0] data_in;
  logic [NVC-1:0]        credit_o;
  logic                  h;
  logic                  ack_h;
  logic                  data_av;
  logic [FLIT_WIDTH-1:0] data;
  logic                  data_ack;
  logic                  sender;
  logic [SEL_W-1:0]      sel_vc;

  // Environment side: upstream router plus switch control plus crossbar.
  modport master (
    output rx, data_in, ack_h, data_ack,
    input  credit_o, h, data_av, data, sender, sel_vc
  );

  // Buffer side.
  modport slave (
    input  rx, data_in, ack_h, data_ack,
    output credit_o, h, data_av, data, sender, sel_vc
  );

endinterface

// File: rtl/router_vc_fifo.sv
// Single virtual-channel circular FIFO; count-based so all DEPTH slots are usable.
module router_vc_fifo #(
  parameter int unsigned FLIT_WIDTH = 16,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [FLIT_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [FLIT_WIDTH-1:0] head,
  output logic                  credit,
  output logic                  empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      first;
  logic [PTR_W-1:0]      last;
  logic [CNT_W-1:0]      count;
  logic                  wr_ok;
  logic                  rd_ok;

  assign credit = (count < CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign wr_ok  = wr && credit;
  assign rd_ok  = rd && !empty;
  // Head comes from storage only, so a new flit is visible one cycle after its write.
  assign head   = mem[first];

  // Pointer and occupancy update; power-of-two depth makes the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      first <= '0;
      last  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) last  <= last + PTR_W'(1);
      if (rd_ok) first <= first + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Flit storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[last] <= wr_data;
  end

endmodule

// File: rtl/router_vc_buffer.sv
// Router input port: NVC flit FIFOs and a packet-level output arbiter toward the crossbar.
module router_vc_buffer
  import hemps_defaults::*;
#(
  parameter int unsigned FLIT_WIDTH = FLIT_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned NVC        = NVC_DEF
) (
  input logic               clock,
  input logic               reset,
  router_vc_buffer_if.slave bus
);

  localparam int unsigned SEL_W = sel_width(NVC);

  logic [NVC-1:0]        credit;
  logic [NVC-1:0]        empty;
  logic [NVC-1:0]        rx_ok;
  logic [NVC-1:0]        wr_en;
  logic [NVC-1:0]        rd_en;
  logic [FLIT_WIDTH-1:0] heads [NVC];

  out_state_e            state;
  logic [SEL_W-1:0]      sel_vc;
  logic [SEL_W-1:0]      last_vc;
  logic [SEL_W-1:0]      pick_vc;
  logic                  pick_found;
  int unsigned           cand;
  logic                  h;
  logic                  sender;
  logic [FLIT_WIDTH-1:0] pay_cnt;
  logic [FLIT_WIDTH-1:0] head_sel;
  logic                  in_data_phase;
  logic                  data_av;
  logic                  pop;

  // Only the lowest-index VC that both requests and has room is written.
  assign rx_ok = bus.rx & credit;
  assign wr_en = rx_ok & (~rx_ok + NVC'(1));

  for (genvar v = 0; v < NVC; v++) begin : g_vc
    router_vc_fifo #(
      .FLIT_WIDTH(FLIT_WIDTH),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .wr     (wr_en[v]),
      .wr_data(bus.data_in),
      .rd     (rd_en[v]),
      .head   (heads[v]),
      .credit (credit[v]),
      .empty  (empty[v])
    );
    assign rd_en[v] = pop && (sel_vc == SEL_W'(v));
  end

  // Round-robin choice: first non-empty VC after the last one served.
  always_comb begin
    pick_found = 1'b0;
    pick_vc    = '0;
    cand       = 0;
    for (int unsigned i = 1; i <= NVC; i++) begin
      cand = (32'(last_vc) + i) % NVC;
      if (!pick_found && !empty[SEL_W'(cand)]) begin
        pick_found = 1'b1;
        pick_vc    = SEL_W'(cand);
      end
    end
  end

  assign head_sel      = heads[sel_vc];
  assign in_data_phase = (state == S_HEADER) || (state == S_SIZE) || (state == S_PAYLOAD);
  assign data_av       = in_data_phase && !empty[sel_vc];
  assign pop           = data_av && bus.data_ack;

  // Output packet sequencer: request, grant, header, size, payload, release.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      sel_vc  <= '0;
      last_vc <= SEL_W'(NVC - 1);
      h       <= 1'b0;
      sender  <= 1'b0;
      pay_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            sel_vc  <= pick_vc;
            last_vc <= pick_vc;
            h       <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.ack_h) begin
            h      <= 1'b0;
            sender <= 1'b1;
            state  <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (pop) state <= S_SIZE;
        end
        S_SIZE: begin
          if (pop) begin
            pay_cnt <= head_sel;
            if (head_sel == '0) begin
              sender <= 1'b0;
              state  <= S_END;
            end else begin
              state  <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (pop) begin
            if (pay_cnt == FLIT_WIDTH'(1)) begin
              sender <= 1'b0;
              state  <= S_END;
            end
            pay_cnt <= pay_cnt - FLIT_WIDTH'(1);
          end
        end
        S_END: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.credit_o = credit;
  assign bus.h        = h;
  assign bus.sender   = sender;
  assign bus.sel_vc   = sel_vc;
  assign bus.data_av  = data_av;
  assign bus.data     = data_av ? head_sel : '0;

endmodule

// File: tb/tb_router_vc_buffer.sv
// Randomized and directed bench for router_vc_buffer against a queue-based packet model.
module tb_router_vc_buffer;
  import hemps_defaults::*;

  localparam int unsigned FW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NVC   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  router_vc_buffer_if #(.FLIT_WIDTH(FW), .NVC(NVC)) bus();

  router_vc_buffer #(
    .FLIT_WIDTH(FW),
    .DEPTH     (DEPTH),
    .NVC       (NVC)
  ) dut (
    .clock(clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: buffered flits per VC, packet ownership and progress.
  flit_t mq   [NVC][$];
  flit_t pend [NVC][$];
  flit_t out_log[$];
  bit    sender_exp  = 1'b0;
  int    lock_vc     = 0;
  int    last_served = NVC - 1;
  int    pos         = 0;
  int    rem         = 0;
  bit    mask_prev [NVC];
  bit    prev_h      = 1'b0;
  bit    grant_prev  = 1'b0;
  int    wr_vc       = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int winner(input logic [NVC-1:0] rx);
    int w;
    w = -1;
    for (int v = 0; v < NVC; v++)
      if (w < 0 && rx[v] && mq[v].size() < DEPTH) w = v;
    return w;
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic step(input logic [NVC-1:0] rx, input flit_t din, input logic ackh, input logic dack);
    bit    dav_exp, do_pop, do_grant;
    bit    mask_now [NVC];
    int    sel, win, exp_vc, c;
    flit_t popped;
    logic [NVC-1:0] cr;
    bus.rx = rx; bus.data_in = din; bus.ack_h = ackh; bus.data_ack = dack;
    @(negedge clk);
    sel = int'(bus.sel_vc);
    cr  = bus.credit_o;
    for (int v = 0; v < NVC; v++) begin
      mask_now[v] = (mq[v].size() != 0);
      check_eq($sformatf("credit%0d", v), 32'(cr[v]), 32'(mq[v].size() < DEPTH));
    end
    dav_exp = sender_exp && (mq[lock_vc].size() != 0);
    check_eq("data_av", 32'(bus.data_av), 32'(dav_exp));
    check_eq("sender", 32'(bus.sender), 32'(sender_exp));
    if (sender_exp) check_eq("sel_lock", 32'(sel), 32'(lock_vc));
    if (dav_exp) check_eq("data", 32'(bus.data), 32'(mq[lock_vc][0]));
    if (grant_prev) check_eq("h_drop", 32'(bus.h), 32'd0);
    if (bus.h && !prev_h) begin
      exp_vc = -1;
      for (int i = 1; i <= NVC; i++) begin
        c = (last_served + i) % NVC;
        if (exp_vc < 0 && mask_prev[c]) exp_vc = c;
      end
      check_eq("rr_pick", 32'(sel), 32'(exp_vc));
      last_served = sel;
    end
    do_grant = bus.h && ackh;
    do_pop   = dav_exp && dack;
    win      = winner(rx);
    prev_h     = bus.h;
    grant_prev = do_grant;
    mask_prev  = mask_now;
    @(posedge clk);
    if (reset) begin
      for (int v = 0; v < NVC; v++) mq[v].delete();
      sender_exp = 1'b0; last_served = NVC - 1; pos = 0;
      grant_prev = 1'b0; prev_h = 1'b0; wr_vc = -1;
    end else begin
      if (do_pop) begin
        popped = mq[lock_vc].pop_front();
        out_log.push_back(popped);
        case (pos)
          0: pos = 1;
          1: begin
            rem = int'(popped);
            if (rem == 0) sender_exp = 1'b0; else pos = 2;
          end
          default: begin
            rem--;
            if (rem == 0) sender_exp = 1'b0;
          end
        endcase
      end
      if (win >= 0) mq[win].push_back(din);
      wr_vc = win;
      if (do_grant) begin
        sender_exp = 1'b1; lock_vc = sel; pos = 0;
      end
    end
    #1;
  endtask

  task automatic grant_wait(input string tag);
    for (int i = 0; i < 20 && !bus.sender; i++) step('0, '0, 1'b1, 1'b0);
    check_eq(tag, 32'(bus.sender), 32'd1);
  endtask

  task automatic gen_packet(input int v);
    int n;
    n = $urandom_range(0, 6);
    pend[v].push_back(flit_t'($urandom));
    pend[v].push_back(flit_t'(n));
    for (int i = 0; i < n; i++) pend[v].push_back(flit_t'($urandom));
  endtask

  task automatic traffic(input int cycles, input int dack_pct, input bit new_pkts, input bit grant_all);
    logic [NVC-1:0] rx;
    int w;
    for (int k = 0; k < cycles; k++) begin
      rx = '0;
      for (int v = 0; v < NVC; v++) begin
        if (new_pkts && pend[v].size() == 0 && $urandom_range(0, 3) == 0) gen_packet(v);
        if (pend[v].size() != 0 && (grant_all || $urandom_range(0, 1) == 1)) rx[v] = 1'b1;
      end
      w = winner(rx);
      step(rx, (w >= 0) ? pend[w][0] : flit_t'($urandom),
           grant_all ? 1'b1 : 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < dack_pct));
      if (wr_vc >= 0) void'(pend[wr_vc].pop_front());
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int left;
    for (int i = 0; i < budget; i++) begin
      left = 0;
      for (int v = 0; v < NVC; v++) left += mq[v].size() + pend[v].size();
      if (left == 0 && !sender_exp) break;
      traffic(1, 100, 1'b0, 1'b1);
    end
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    left = 0;
    for (int v = 0; v < NVC; v++) left += mq[v].size() + pend[v].size();
    check_eq({tag, "_left"}, 32'(left), 32'd0);
    check_eq({tag, "_sender"}, 32'(bus.sender), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    flit_t exp1 [4];
    flit_t exp3 [7];
    for (int v = 0; v < NVC; v++) mask_prev[v] = 1'b0;
    reset = 1'b1;
    bus.rx = '0; bus.data_in = '0; bus.ack_h = 1'b0; bus.data_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_credit", 32'(bus.credit_o), 32'(2'b11));
    check_eq("rst_h", 32'(bus.h), 32'd0);
    check_eq("rst_data_av", 32'(bus.data_av), 32'd0);
    check_eq("rst_sender", 32'(bus.sender), 32'd0);
    check_eq("rst_data", 32'(bus.data), 32'd0);
    check_eq("rst_sel", 32'(bus.sel_vc), 32'd0);

    // Basic packet on VC0.
    out_log.delete();
    step(2'b01, 16'h0011, 1'b0, 1'b1);
    step(2'b01, 16'h0002, 1'b0, 1'b1);
    step(2'b01, 16'hAAAA, 1'b0, 1'b1);
    step(2'b01, 16'hBBBB, 1'b0, 1'b1);
    grant_wait("t1_grant");
    check_eq("t1_sel", 32'(bus.sel_vc), 32'd0);
    drain("t1", 50);
    exp1 = '{16'h0011, 16'h0002, 16'hAAAA, 16'hBBBB};
    check_eq("t1_count", 32'(out_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < out_log.size(); i++)
      check_eq($sformatf("t1_flit%0d", i), 32'(out_log[i]), 32'(exp1[i]));

    // Zero-length payload.
    out_log.delete();
    step(2'b01, 16'h0022, 1'b0, 1'b0);
    step(2'b01, 16'h0000, 1'b0, 1'b0);
    grant_wait("t2_grant");
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    check_eq("t2_sender", 32'(bus.sender), 32'd0);
    check_eq("t2_data_av", 32'(bus.data_av), 32'd0);
    check_eq("t2_count", 32'(out_log.size()), 32'd2);
    drain("t2", 20);

    // Two VCs pending: whole packets, no interleaving.
    out_log.delete();
    exp3 = '{16'h0100, 16'h0002, 16'h1001, 16'h1002, 16'h0200, 16'h0001, 16'h2001};
    for (int i = 0; i < 4; i++) step(2'b01, exp3[i], 1'b0, 1'b0);
    for (int i = 4; i < 7; i++) step(2'b10, exp3[i], 1'b0, 1'b0);
    drain("t3", 100);
    check_eq("t3_count", 32'(out_log.size()), 32'd7);
    for (int i = 0; i < 7 && i < out_log.size(); i++)
      check_eq($sformatf("t3_flit%0d", i), 32'(out_log[i]), 32'(exp3[i]));

    // Fill VC1 to capacity, overflow attempt, then release one slot.
    step(2'b10, 16'h0300, 1'b0, 1'b0);
    step(2'b10, 16'd14, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(2'b10, flit_t'(16'h3000 + i), 1'b0, 1'b0);
    check_eq("t4_full", 32'(bus.credit_o[1]), 32'd0);
    step(2'b10, 16'hDEAD, 1'b0, 1'b0);
    check_eq("t4_ignored", 32'(bus.credit_o[1]), 32'd0);
    grant_wait("t4_grant");
    check_eq("t4_still_full", 32'(bus.credit_o[1]), 32'd0);
    step('0, '0, 1'b0, 1'b1);
    check_eq("t4_credit_back", 32'(bus.credit_o[1]), 32'd1);
    drain("t4", 100);

    // Streaming write and read on one VC through pointer wrap.
    step(2'b01, 16'h0400, 1'b0, 1'b0);
    step(2'b01, 16'd42, 1'b0, 1'b0);
    step(2'b01, 16'h4000, 1'b0, 1'b0);
    step(2'b01, 16'h4001, 1'b0, 1'b0);
    grant_wait("t5_grant");
    for (int i = 0; i < 40; i++) begin
      check_eq("t5_stream_av", 32'(bus.data_av), 32'd1);
      step(2'b01, flit_t'(16'h4002 + i), 1'b0, 1'b1);
    end
    drain("t5", 100);

    // Reset in the middle of a payload.
    step(2'b01, 16'h0500, 1'b0, 1'b0);
    step(2'b01, 16'd8, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(2'b01, flit_t'(16'h5000 + i), 1'b0, 1'b0);
    grant_wait("t6_grant");
    repeat (3) step('0, '0, 1'b0, 1'b1);
    reset = 1'b1;
    step('0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    check_eq("t6_credit", 32'(bus.credit_o), 32'(2'b11));
    check_eq("t6_data_av", 32'(bus.data_av), 32'd0);
    check_eq("t6_h", 32'(bus.h), 32'd0);
    check_eq("t6_sender", 32'(bus.sender), 32'd0);
    step('0, '0, 1'b0, 1'b1);
    check_eq("t6_quiet", 32'(bus.h), 32'd0);

    // Random traffic: light then heavy backpressure, then drain.
    traffic(400, 80, 1'b1, 1'b0);
    traffic(400, 15, 1'b1, 1'b0);
    drain("rnd", 3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_vc_buffer.md
ROUTER_VC_BUFFER -- requirements
Module: router_vc_buffer

Interface
REQ-001 Parameter FLIT_WIDTH, default 16, flit width in bits.
REQ-002 Parameter DEPTH, default 16, slots per virtual channel; power of two, minimum 4.
REQ-003 Parameter NVC, default 2, virtual channels per input port; minimum 1, maximum 4.
REQ-004 clock  in  1  single clock; all logic samples on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rx  in  NVC  write strobe per VC from upstream.
REQ-007 data_in  in  FLIT_WIDTH  flit from upstream, shared by all VCs.
REQ-008 credit_o  out  NVC  per-VC credit to upstream; 1 = slot free.
REQ-009 h  out  1  routing request for the head packet of the locked VC.
REQ-010 ack_h  in  1  routing grant from switch control.
REQ-011 data_av  out  1  flit valid toward crossbar.
REQ-012 data  out  FLIT_WIDTH  flit toward crossbar.
REQ-013 data_ack  in  1  crossbar consumed current flit.
REQ-014 sender  out  1  high from routing grant until the last flit is acknowledged.
REQ-015 sel_vc  out  $clog2(NVC) (min 1)  VC currently owning the output.

Function
REQ-016 Each VC SHALL be an independent circular FIFO with first/last pointers and a count of width $clog2(DEPTH)+1, storing up to DEPTH flits (no wasted slot).
REQ-017 credit_o[v] SHALL be 1 exactly when count[v] < DEPTH, derived from registered state.
REQ-018 A write to VC v SHALL occur when rx[v]=1 and credit_o[v]=1; rx[v] with credit_o[v]=0 SHALL be ignored, contents unchanged.
REQ-019 More than one rx bit high in a cycle SHALL write only the lowest-index VC with credit.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 A flit written at edge t SHALL be visible at the FIFO head no earlier than the cycle after edge t (no bypass).
REQ-022 Simultaneous write and read on the same VC SHALL leave count unchanged; on a full VC, a read SHALL raise credit_o the following cycle.
REQ-023 Packet format: flit 0 header, flit 1 size N, then N payload flits; N=0 legal.
REQ-024 Output FSM states: S_IDLE, S_REQ, S_HEADER, S_SIZE, S_PAYLOAD, S_END.
REQ-025 S_IDLE: round-robin pick among non-empty VCs, starting after the last served VC; load sel_vc; go to S_REQ.
REQ-026 S_REQ: h=1; on ack_h=1 set sender=1, clear h, go to S_HEADER.
REQ-027 S_HEADER/S_SIZE/S_PAYLOAD: data_av=1 when the selected VC is non-empty; data = head flit; on data_ack=1 pop and advance.
REQ-028 S_SIZE pop SHALL load a payload counter with N; if N=0 go to S_END, else S_PAYLOAD.
REQ-029 S_PAYLOAD SHALL decrement per acknowledged flit; acknowledged flit at count 1 goes to S_END.
REQ-030 S_END: sender=0, data_av=0; next cycle S_IDLE.
REQ-031 sel_vc SHALL stay constant from S_REQ through S_END (packet-level lock; no flit interleaving).
REQ-032 data_ack while data_av=0 SHALL be ignored.
REQ-033 A VC empty mid-packet SHALL hold data_av=0 and FSM state until data arrives.

Reset
REQ-034 On reset: pointers and counts 0, credit_o all 1, FSM S_IDLE, round-robin pointer to VC NVC-1 (VC 0 first), h=0, data_av=0, sender=0, data=0, sel_vc=0.
REQ-035 Reset mid-packet SHALL discard all buffered flits and abandon the packet in one cycle.

Structure
REQ-036 Flit type, FSM state enum and default FLIT_WIDTH/DEPTH/NVC SHALL live in hemps_defaults.
REQ-037 Per-VC storage SHALL be one sub-module, router_vc_fifo, instantiated NVC times.

Verification
REQ-038 Reset, write 0x0011,0x0002,0xAAAA,0xBBBB on VC0, ack_h after 2 cycles, data_ack every cycle -> four flits in order, sender drops after 0xBBBB, sel_vc=0.
REQ-039 Fill VC1 with DEPTH=16 flits, no reads -> credit_o[1]=0 after 16th write; 17th rx[1] ignored; one pop -> credit_o[1]=1 next cycle.
REQ-040 Packets pending on VC0 and VC1 simultaneously -> VC0 served whole, then VC1; no interleaving on data.
REQ-041 Size-0 packet 0x0022,0x0000 -> two flits out, S_END after size flit, sender 0.
REQ-042 Assert reset while in S_PAYLOAD with 5 flits buffered -> next cycle all counts 0, credit_o all 1, data_av=0, h=0.
REQ-043 Write/read same VC for 40 cycles with DEPTH=16 -> pointers wrap twice, data order preserved, count constant.
